biquad8_coeff_sequencer: RTL and testbench

Controller that loads coefficients into one 8-sample incremental biquad DSP cascade.
- Software stages one 18-bit coefficient per DSP into a local register file.
- On commit, the block shifts the full set down the DSP B1 cascade using the write strobe, then pulses the update strobe so every B2 register loads at once.
- Sits between the register-bus decode and the biquad's coeff_dat/coeff_wr/coeff_update inputs; one instance per biquad.

---
 rtl/biquad8_coeff_sequencer_pkg.sv | 19 +
 rtl/biquad8_coeff_sequencer_if.sv | 37 +++
 rtl/biquad8_coeff_sequencer_stage.sv | 42 ++++
 rtl/biquad8_coeff_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_biquad8_coeff_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/biquad8_coeff_sequencer_pkg.sv
// Shared types and constants for the biquad coefficient sequencer.
// Defines the coefficient width, the cascade length helper and the FSM state type.
package biquad_coeff_pkg;

    localparam int COEFF_W = 18;

    // Number of cascaded DSPs in a biquad that processes nsamp samples per clock.
    function automatic int ncoeff(input int nsamp);
        return 2 * (nsamp - 2);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        UPDATE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/biquad8_coeff_sequencer_if.sv
// Register-bus side and biquad side signals of the coefficient sequencer.
// The master modport is the register decode / bench, the slave modport is the sequencer.
interface biquad8_coeff_sequencer_if #(
    parameter int NSAMP = 8
);
    import biquad_coeff_pkg::*;

    localparam int ADDR_W = $clog2(ncoeff(NSAMP));

    // Staging / control side
    logic               cfg_wr_i;
    logic [ADDR_W-1:0]  cfg_addr_i;
    logic [COEFF_W-1:0] cfg_dat_i;      // two's complement coefficient
    logic               commit_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    // Biquad side
    logic [COEFF_W-1:0] coeff_dat_o;
    logic               coeff_wr_o;
    logic               coeff_update_o;
    logic               bypass_o;

    modport master (
        output cfg_wr_i, cfg_addr_i, cfg_dat_i, commit_i,
        input  busy_o, done_o, err_o,
        input  coeff_dat_o, coeff_wr_o, coeff_update_o, bypass_o
    );

    modport slave (
        input  cfg_wr_i, cfg_addr_i, cfg_dat_i, commit_i,
        output busy_o, done_o, err_o,
        output coeff_dat_o, coeff_wr_o, coeff_update_o, bypass_o
    );

endinterface

// File: rtl/biquad8_coeff_sequencer_stage.sv
// Staging register file: one coefficient per cascaded DSP.
// Async-reset write port, out-of-range address flag, combinational read by load index.
module biquad_coeff_stage
    import biquad_coeff_pkg::*;
#(
    parameter int NCOEFF = 12,
    parameter int ADDR_W = $clog2(NCOEFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [COEFF_W-1:0] i_wr_dat,
    output logic               o_addr_oor,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [COEFF_W-1:0] o_rd_dat
);

    logic [COEFF_W-1:0] w_words [NCOEFF];

    // Addresses past the last DSP never match an entry; flag them for the sticky error.
    assign o_addr_oor = (int'(i_wr_addr) >= NCOEFF);

    for (genvar gi = 0; gi < NCOEFF; gi++) begin : g_stage
        logic [COEFF_W-1:0] r_word;

        // Each entry loads only when its own index is addressed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (i_wr_en && (int'(i_wr_addr) == gi)) begin
                r_word <= i_wr_dat;
            end
        end

        assign w_words[gi] = r_word;
    end

    // The load index never exceeds NCOEFF-1, so the read stays inside the file.
    assign o_rd_dat = w_words[i_rd_addr];

endmodule

// File: rtl/biquad8_coeff_sequencer.sv
// Coefficient load sequencer for one 8-sample incremental biquad DSP cascade.
// Streams the staged set down the B1 cascade (strobe one cycle ahead of data),
// then pulses the update strobe so all B2 registers load together.
// Optional feature macro: BIQUAD_COEFF_BYPASS_HOLD_EN (bypass request plus a
// HOLD_CLKS-long flush period before completion).
module biquad8_coeff_sequencer
    import biquad_coeff_pkg::*;
#(
    parameter int NSAMP     = 8,
    parameter int ADDR_W    = $clog2(ncoeff(NSAMP)),
    parameter int HOLD_CLKS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    biquad8_coeff_sequencer_if.slave  bus
);

    localparam int NCOEFF = ncoeff(NSAMP);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NCOEFF - 1);

    state_t             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_k, w_k_next;
    logic               r_pending, w_pending_next;
    logic               r_err, w_err_next;

    logic               r_busy;
    logic               r_done;
    logic               r_coeff_wr;
    logic               r_coeff_update;
    logic               r_bypass;
    logic [COEFF_W-1:0] r_coeff_dat;

    logic               w_done_next;
    logic               w_bypass_next;
    logic [COEFF_W-1:0] w_coeff_dat_next;

    logic               w_stage_wr;
    logic               w_addr_oor;
    logic               w_wr_err;
    logic               w_start;
    logic [COEFF_W-1:0] w_rd_dat;

    // Staging is single-buffered: writes land only while idle, anything else is an error.
    assign w_stage_wr = bus.cfg_wr_i && (r_state == IDLE);
    assign w_wr_err   = bus.cfg_wr_i && ((r_state != IDLE) || w_addr_oor);
    assign w_start    = (r_state == IDLE) && (bus.commit_i || r_pending);

    biquad_coeff_stage #(
        .NCOEFF (NCOEFF),
        .ADDR_W (ADDR_W)
    ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_stage_wr),
        .i_wr_addr  (bus.cfg_addr_i),
        .i_wr_dat   (bus.cfg_dat_i),
        .o_addr_oor (w_addr_oor),
        .i_rd_addr  (r_k),
        .o_rd_dat   (w_rd_dat)
    );

`ifdef BIQUAD_COEFF_BYPASS_HOLD_EN
    localparam int HOLD_W = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CLKS - 1);

    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;

    // Flush-period down-counter, only meaningful in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_next;
        end
    end
`endif

    // Next-state, load index, pending request and sticky error.
    always_comb begin
        w_state_next   = r_state;
        w_k_next       = r_k;
        w_pending_next = r_pending;
        w_err_next     = r_err;
        w_done_next    = 1'b0;
`ifdef BIQUAD_COEFF_BYPASS_HOLD_EN
        w_hold_cnt_next = r_hold_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next   = STREAM;
                    w_k_next       = K_LAST;
                    w_pending_next = 1'b0;
                    w_err_next     = 1'b0;
                end
            end
            STREAM: begin
                if (bus.commit_i) w_pending_next = 1'b1;
                if (r_k == '0) begin
                    w_state_next = UPDATE;
                end else begin
                    w_k_next = r_k - 1'b1;
                end
            end
            UPDATE: begin
                if (bus.commit_i) w_pending_next = 1'b1;
`ifdef BIQUAD_COEFF_BYPASS_HOLD_EN
                w_state_next    = HOLD;
                w_hold_cnt_next = HOLD_LAST;
`else
                w_state_next = IDLE;
                w_done_next  = 1'b1;
`endif
            end
            HOLD: begin
`ifdef BIQUAD_COEFF_BYPASS_HOLD_EN
                if (bus.commit_i) w_pending_next = 1'b1;
                if (r_hold_cnt == '0) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 1'b1;
                end
`else
                w_state_next = IDLE;
`endif
            end
            default: w_state_next = IDLE;
        endcase
        // A bad write in the accept cycle still leaves the flag set.
        if (w_wr_err) w_err_next = 1'b1;
    end

    // Data lags the strobe by one cycle to match the biquad's registered B1 clock enable.
    always_comb begin
        w_coeff_dat_next = '0;
        if (r_state == STREAM) w_coeff_dat_next = w_rd_dat;
`ifdef BIQUAD_COEFF_BYPASS_HOLD_EN
        w_bypass_next = (w_state_next != IDLE);
`else
        w_bypass_next = 1'b0;
`endif
    end

    // State, counters and registered outputs; reset drops every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_k            <= '0;
            r_pending      <= 1'b0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_coeff_wr     <= 1'b0;
            r_coeff_update <= 1'b0;
            r_bypass       <= 1'b0;
            r_coeff_dat    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_k            <= w_k_next;
            r_pending      <= w_pending_next;
            r_err          <= w_err_next;
            r_busy         <= (w_state_next != IDLE);
            r_done         <= w_done_next;
            r_coeff_wr     <= (w_state_next == STREAM);
            r_coeff_update <= (w_state_next == UPDATE);
            r_bypass       <= w_bypass_next;
            r_coeff_dat    <= w_coeff_dat_next;
        end
    end

    assign bus.busy_o         = r_busy;
    assign bus.done_o         = r_done;
    assign bus.err_o          = r_err;
    assign bus.coeff_dat_o    = r_coeff_dat;
    assign bus.coeff_wr_o     = r_coeff_wr;
    assign bus.coeff_update_o = r_coeff_update;
    assign bus.bypass_o       = r_bypass;

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// Self-checking bench for biquad8_coeff_sequencer with a downstream biquad model.
// Expected coefficient words are queued when a load is requested and compared
// as the modelled biquad clocks them into its B1 cascade.
`timescale 1ns/1ps
module tb_biquad8_coeff_sequencer;

    localparam int NSAMP  = 8;
    localparam int NC     = 12;
    localparam int AW     = 4;
    localparam int HOLD   = 16;
`ifdef BIQUAD_COEFF_BYPASS_HOLD_EN
    localparam int DONE_OFS = NC + HOLD + 2;
    localparam int BYP_CNT  = NC + HOLD + 1;
`else
    localparam int DONE_OFS = NC + 2;
    localparam int BYP_CNT  = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    biquad8_coeff_sequencer_if #(.NSAMP(NSAMP)) bus ();

    biquad8_coeff_sequencer #(
        .NSAMP     (NSAMP),
        .HOLD_CLKS (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Bench staging model and scoreboard
    logic [17:0] m_stage [NC];
    logic [17:0] exp_q [$];
    logic [17:0] e_dat;
    int wr_q [$];
    int upd_q [$];
    int done_q [$];
    int busy_q [$];
    int byp_q [$];

    // Downstream biquad: registered CE, NC-deep B1 shift, B2 loads on registered update.
    logic        ce_d, upd_d;
    logic [17:0] b1 [NC];
    logic [17:0] b2 [NC];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_d  <= 1'b0;
            upd_d <= 1'b0;
        end else begin
            ce_d  <= bus.coeff_wr_o;
            upd_d <= bus.coeff_update_o;
            if (ce_d) begin
                b1[0] <= bus.coeff_dat_o;
                for (int j = 1; j < NC; j++) b1[j] <= b1[j-1];
            end
            if (upd_d) begin
                for (int j = 0; j < NC; j++) b2[j] <= b1[j];
            end
        end
    end

    // Event recorder and data scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.coeff_wr_o)     wr_q.push_back(cyc);
            if (bus.coeff_update_o) upd_q.push_back(cyc);
            if (bus.busy_o)         busy_q.push_back(cyc);
            if (bus.bypass_o)       byp_q.push_back(cyc);
            if (bus.done_o) begin
                done_q.push_back(cyc);
                $display("load complete at cycle %0d", cyc);
            end
            if (ce_d) begin
                check("dat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e_dat = exp_q.pop_front();
                    check("coeff_dat", 32'(bus.coeff_dat_o), 32'(e_dat));
                end
            end else begin
                check("dat_idle_zero", 32'(bus.coeff_dat_o), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_rec();
        wr_q.delete();
        upd_q.delete();
        done_q.delete();
        busy_q.delete();
        byp_q.delete();
    endtask

    task automatic push_load();
        for (int i = NC - 1; i >= 0; i--) exp_q.push_back(m_stage[i]);
    endtask

    // One staging write issued while the sequencer is idle.
    task automatic wr_stage(input int a, input logic [17:0] d);
        bus.cfg_wr_i   = 1'b1;
        bus.cfg_addr_i = AW'(a);
        bus.cfg_dat_i  = d;
        step();
        bus.cfg_wr_i   = 1'b0;
        if (a < NC) m_stage[a] = d;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_busy"},   32'(bus.busy_o), 0);
        check({pfx, "_done"},   32'(bus.done_o), 0);
        check({pfx, "_err"},    32'(bus.err_o), 0);
        check({pfx, "_dat"},    32'(bus.coeff_dat_o), 0);
        check({pfx, "_wr"},     32'(bus.coeff_wr_o), 0);
        check({pfx, "_update"}, 32'(bus.coeff_update_o), 0);
        check({pfx, "_bypass"}, 32'(bus.bypass_o), 0);
    endtask

    task automatic check_single_load(input int t0);
        check("wr_count", wr_q.size(), NC);
        if (wr_q.size() != 0) begin
            check("wr_first", wr_q[0], t0 + 1);
            check("wr_last", wr_q[wr_q.size()-1], t0 + NC);
        end
        check("upd_count", upd_q.size(), 1);
        if (upd_q.size() != 0) check("upd_cycle", upd_q[0], t0 + NC + 1);
        check("done_count", done_q.size(), 1);
        if (done_q.size() != 0) check("done_cycle", done_q[0], t0 + DONE_OFS);
        check("busy_len", busy_q.size(), DONE_OFS - 1);
        if (busy_q.size() != 0) check("busy_first", busy_q[0], t0 + 1);
        check("bypass_len", byp_q.size(), BYP_CNT);
        if (byp_q.size() != 0) check("bypass_first", byp_q[0], t0 + 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic check_b2(input string tag);
        for (int j = 0; j < NC; j++) check(tag, 32'(b2[j]), 32'(m_stage[j]));
    endtask

    task automatic start_load(output int t0);
        push_load();
        t0 = cyc;
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
    endtask

    initial begin
        int t0;
        bus.cfg_wr_i   = 1'b0;
        bus.cfg_addr_i = '0;
        bus.cfg_dat_i  = '0;
        bus.commit_i   = 1'b0;
        for (int i = 0; i < NC; i++) m_stage[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Load 1: incrementing pattern
        for (int i = 0; i < NC; i++) wr_stage(i, 18'(32'h100 + i));
        clear_rec();
        start_load(t0);
        idle_cycles(DONE_OFS + 4);
        check_single_load(t0);
        check_b2("b2_incr");
        check("err_after_load1", 32'(bus.err_o), 0);

        // Out-of-range write in IDLE, then a write while streaming
        wr_stage(NC, 18'h3FFFF);
        check("err_oor", 32'(bus.err_o), 1);
        clear_rec();
        start_load(t0);
        step();
        check("err_clr_on_accept", 32'(bus.err_o), 0);
        idle_cycles(3);
        bus.cfg_wr_i   = 1'b1;
        bus.cfg_addr_i = AW'(3);
        bus.cfg_dat_i  = 18'h3FFFF;
        step();
        bus.cfg_wr_i   = 1'b0;
        check("err_busy_wr", 32'(bus.err_o), 1);
        idle_cycles(DONE_OFS - 1);
        check_single_load(t0);
        check("b2_keep3", 32'(b2[3]), 32'h103);

        // Three commits during a load collapse into one extra load
        clear_rec();
        push_load();
        start_load(t0);
        check("err_clr2", 32'(bus.err_o), 0);
        step();
        step();
        bus.commit_i = 1'b1;
        step();
        step();
        bus.commit_i = 1'b0;
        idle_cycles(4);
        bus.commit_i = 1'b1;
        step();
        bus.commit_i = 1'b0;
        idle_cycles(2 * DONE_OFS - 2);
        check("pend_wr_count", wr_q.size(), 2 * NC);
        if (wr_q.size() > NC) check("pend_wr2_first", wr_q[NC], t0 + DONE_OFS + 1);
        check("pend_upd_count", upd_q.size(), 2);
        check("pend_done_count", done_q.size(), 2);
        if (done_q.size() > 1) check("pend_done2", done_q[1], t0 + 2 * DONE_OFS);
        check("pend_sb_drained", exp_q.size(), 0);

        // Reset in the middle of the stream
        clear_rec();
        start_load(t0);
        idle_cycles(5);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        for (int i = 0; i < NC; i++) m_stage[i] = '0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(6);
        check("midrst_no_update", upd_q.size(), 0);
        check("midrst_no_done", done_q.size(), 0);

        // Write and commit together: the fresh word is streamed first
        clear_rec();
        bus.cfg_wr_i   = 1'b1;
        bus.cfg_addr_i = AW'(NC - 1);
        bus.cfg_dat_i  = 18'h2AAAA;
        m_stage[NC-1]  = 18'h2AAAA;
        start_load(t0);
        bus.cfg_wr_i   = 1'b0;
        idle_cycles(DONE_OFS + 4);
        check_single_load(t0);
        check_b2("b2_after_reset");

        // Random signed coefficients
        for (int i = 0; i < NC; i++) wr_stage(i, 18'($urandom));
        clear_rec();
        start_load(t0);
        idle_cycles(DONE_OFS + 4);
        check_single_load(t0);
        check_b2("b2_random");
        check("err_final", 32'(bus.err_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
